// File: rtl/unsigned_fixed_point_block_averager_if.sv
// Handshake bundle between the Q5.4 sum producer, the block averager and
// the downstream Q4.4 consumer.
interface unsigned_fixed_point_block_averager_if;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_sum;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_avg;
    logic       out_sat;

    // Averager side: consumes samples, produces block results.
    modport slave (
        input  in_valid,
        input  in_sum,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_avg,
        output out_sat
    );

    // Environment side: produces samples, consumes block results.
    modport master (
        output in_valid,
        output in_sum,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_avg,
        input  out_sat
    );
endinterface

// File: rtl/unsigned_fixed_point_block_averager.sv
// Block averager: accumulates 2^LOG2N unsigned Q5.4 samples and emits the
// block mean as Q4.4, rounded half-up and clamped to 8'hFF.
// Legal LOG2N range is 1..6.
module unsigned_fixed_point_block_averager #(
    parameter int LOG2N = 2
) (
    input  logic clk,
    input  logic rst,
    unsigned_fixed_point_block_averager_if.slave bus
);

    // Accumulator wide enough for N full-scale samples.
    localparam int ACC_W  = 9 + LOG2N;
    // Rounded total carries one extra bit so the half-LSB add cannot wrap.
    localparam int RND_W  = ACC_W + 1;
    // Mean after the shift: always 10 bits, bits [9:8] flag saturation.
    localparam int MEAN_W = RND_W - LOG2N;

    localparam logic [RND_W-1:0] HALF     = RND_W'(1) << (LOG2N - 1);
    localparam logic [LOG2N-1:0] CNT_LAST = '1;

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q,   acc_d;
    logic [LOG2N-1:0] cnt_q,   cnt_d;
    logic [7:0]       avg_q,   avg_d;
    logic             sat_q,   sat_d;

    logic [RND_W-1:0]  total;
    logic [RND_W-1:0]  rounded;
    logic [MEAN_W-1:0] mean;
    logic              mean_sat;

    // Block total including the sample on the bus, then round and scale.
    always_comb begin
        total    = {1'b0, acc_q} + {{(LOG2N + 1){1'b0}}, bus.in_sum};
        rounded  = total + HALF;
        mean     = rounded[RND_W-1:LOG2N];
        mean_sat = |mean[MEAN_W-1:8];
    end

    // Next-state: accept samples in ACCUM, park the result in HOLD.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        avg_d   = avg_q;
        sat_d   = sat_q;
        case (state_q)
            ST_ACCUM: begin
                if (bus.in_valid) begin
                    if (cnt_q == CNT_LAST) begin
                        // Last sample of the block: latch the mean, restart.
                        avg_d   = mean_sat ? 8'hFF : mean[7:0];
                        sat_d   = mean_sat;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_HOLD;
                    end else begin
                        acc_d = acc_q + {{LOG2N{1'b0}}, bus.in_sum};
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                // The handshake edge itself accepts no sample.
                if (bus.out_ready) begin
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    // State registers; reset discards any partial block or pending result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            avg_q   <= 8'h00;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            avg_q   <= avg_d;
            sat_q   <= sat_d;
        end
    end

    // Handshake outputs depend on state only.
    assign bus.in_ready  = (state_q == ST_ACCUM);
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.out_avg   = avg_q;
    assign bus.out_sat   = sat_q;

endmodule

// File: tb/tb_unsigned_fixed_point_block_averager.sv
// Bench for the block averager (N = 4): directed scenarios followed by
// random traffic, checked against a queue-based model of the block mean.
module tb_unsigned_fixed_point_block_averager;

    localparam int LOG2N = 2;
    localparam int N     = 1 << LOG2N;

    logic clk;
    logic rst;

    unsigned_fixed_point_block_averager_if bus();

    unsigned_fixed_point_block_averager #(.LOG2N(LOG2N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: accepted samples of the open block, plus the
    // pending result while one is waiting for the consumer.
    int   m_samples[$];
    bit   m_hold;
    int   m_avg;
    bit   m_sat;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_samples.delete();
        m_hold = 1'b0;
    endtask

    // Called at a falling edge: check outputs, drive inputs for the next
    // rising edge, advance the model, and move to the next falling edge.
    task automatic step(input bit v, input logic [8:0] s, input bit ordy);
        int sum;
        int mean;
        chk("in_ready", int'(bus.in_ready), int'(!m_hold));
        chk("out_valid", int'(bus.out_valid), int'(m_hold));
        if (m_hold) begin
            chk("out_avg", int'(bus.out_avg), m_avg);
            chk("out_sat", int'(bus.out_sat), int'(m_sat));
        end
        bus.in_valid  = v;
        bus.in_sum    = s;
        bus.out_ready = ordy;
        if (!m_hold) begin
            if (v) begin
                m_samples.push_back(int'(s));
                if (m_samples.size() == N) begin
                    sum = 0;
                    foreach (m_samples[i]) sum += m_samples[i];
                    mean = (sum + N / 2) / N;
                    m_sat = (mean > 255);
                    m_avg = m_sat ? 255 : mean;
                    m_hold = 1'b1;
                    m_samples.delete();
                end
            end
        end else if (ordy) begin
            m_hold = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [8:0] mix [4];
        // Reset with an active sample on the bus: nothing may be counted.
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_sum    = 9'h1FF;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_avg", int'(bus.out_avg), 0);
        chk("rst_out_sat", int'(bus.out_sat), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        bus.in_valid = 1'b0;
        #3 rst = 1'b0;
        model_reset();
        @(negedge clk);

        // Basic mean, back-to-back, consumer always ready.
        for (int i = 0; i < 4; i++) step(1'b1, 9'h01E, 1'b1);
        chk("basic_avg", int'(bus.out_avg), 8'h1E);
        chk("basic_sat", int'(bus.out_sat), 0);
        step(1'b0, 9'h000, 1'b1);
        step(1'b0, 9'h000, 1'b1);

        // Mixed values with idle gaps.
        mix[0] = 9'h030; mix[1] = 9'h030; mix[2] = 9'h100; mix[3] = 9'h010;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, mix[i], 1'b1);
            if (i < 3) begin
                step(1'b0, 9'h1FF, 1'b1);
                step(1'b0, 9'h1FF, 1'b1);
            end
        end
        chk("gap_avg", int'(bus.out_avg), 8'h5C);
        step(1'b0, 9'h000, 1'b1);

        // Rounding: exactly half rounds up, a quarter rounds down.
        step(1'b1, 9'h001, 1'b1);
        step(1'b1, 9'h000, 1'b1);
        step(1'b1, 9'h000, 1'b1);
        step(1'b1, 9'h001, 1'b1);
        chk("round_half_avg", int'(bus.out_avg), 8'h01);
        step(1'b0, 9'h000, 1'b1);
        step(1'b1, 9'h001, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 9'h000, 1'b1);
        chk("round_down_avg", int'(bus.out_avg), 8'h00);
        step(1'b0, 9'h000, 1'b1);

        // Saturation, then an in-range block just below the clamp.
        for (int i = 0; i < 4; i++) step(1'b1, 9'h1FF, 1'b1);
        chk("sat_avg", int'(bus.out_avg), 8'hFF);
        chk("sat_flag", int'(bus.out_sat), 1);
        step(1'b0, 9'h000, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 9'h0F0, 1'b1);
        chk("nosat_avg", int'(bus.out_avg), 8'hF0);
        chk("nosat_flag", int'(bus.out_sat), 0);
        step(1'b0, 9'h000, 1'b1);

        // Backpressure: result held for 5 cycles with samples offered.
        for (int i = 0; i < 4; i++) step(1'b1, 9'h050, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 9'h0AA, 1'b0);
        // Handshake cycle: the offered sample must not be taken.
        step(1'b1, 9'h0AA, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 9'h0AA, 1'b1);
        chk("bp_next_avg", int'(bus.out_avg), 8'hAA);
        step(1'b0, 9'h000, 1'b1);

        // Mid-block reset discards the partial block.
        step(1'b1, 9'h100, 1'b1);
        step(1'b1, 9'h100, 1'b1);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #2;
        chk("midrst_in_ready", int'(bus.in_ready), 1);
        chk("midrst_out_valid", int'(bus.out_valid), 0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++) step(1'b1, 9'h010, 1'b1);
        chk("midrst_avg", int'(bus.out_avg), 8'h10);
        step(1'b0, 9'h000, 1'b1);

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            logic [8:0] s;
            s = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom_range(0, 511));
            step($urandom_range(0, 3) != 0, s, $urandom_range(0, 2) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/unsigned_fixed_point_block_averager.md
# unsigned_fixed_point_block_averager

Downstream consumer of the unsigned pipelined Q4.4 adder. Takes the adder's 9-bit Q5.4 `Sum` stream through a valid/ready handshake, accumulates blocks of 2^LOG2N samples, and emits each block's mean. The mean is rounded half-up and saturated back to 8-bit Q4.4, so the result can feed another adder stage.

## Interface
- LOG2N, default 2: log2 of the block length N. The legal range is 1..6.
- clk  input  1  rising-edge clock shared with the adder.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  `in_sum` is valid this cycle.
- in_ready  output  1  the block can accept a sample this cycle.
- in_sum  input  9  unsigned Q5.4 sample, the adder `Sum` output.
- out_valid  output  1  `out_avg` and `out_sat` hold a completed block result.
- out_ready  input  1  the consumer takes the result this cycle.
- out_avg  output  8  unsigned Q4.4 block mean, rounded and saturated.
- out_sat  output  1  the result was clamped to 8'hFF.

## Operation
- Internal state:
  - acc: accumulator, 9+LOG2N bits wide, so it cannot overflow.
  - cnt: sample counter, LOG2N bits wide.
  - 2-state FSM with states ACCUM and HOLD.
- ACCUM state:
  - `in_ready` = 1 and `out_valid` = 0.
  - A sample is accepted when `in_valid` and `in_ready` are both 1: acc += `in_sum` and cnt += 1.
  - When the accepted sample is the Nth of the block (cnt == N-1 before the increment):
    - The total is acc + `in_sum`, including the sample just accepted.
    - mean = (total + 2^(LOG2N-1)) >> LOG2N. The add is computed 1 bit wider so no carry is lost.
    - If mean > 255: `out_avg` = 8'hFF and `out_sat` = 1. Otherwise `out_avg` = mean[7:0] and `out_sat` = 0.
    - Register the result, clear acc and cnt to 0, and go to HOLD.
- HOLD state:
  - `in_ready` = 0, so no sample is accepted and `in_sum` is ignored.
  - `out_valid` = 1, and `out_avg` and `out_sat` stay stable.
  - When `out_ready` = 1, the result is consumed: the next state is ACCUM and `out_valid` drops next cycle.
- `in_ready` is a function of state only. `out_avg` and `out_sat` are registered.
- Idle cycles (`in_valid` = 0) in ACCUM leave acc and cnt unchanged. A block may be spread over any number of cycles.

## Timing
- Values during and after reset:
  - While `rst` = 1, asynchronously: state = ACCUM, acc = 0, cnt = 0, `out_valid` = 0, `out_avg` = 8'h00, `out_sat` = 0.
  - `in_ready` = 1 while in reset and after it.
- Throughput and latency:
  - Accepts 1 sample per cycle in ACCUM.
  - `out_valid` rises on the clock edge that accepts the Nth sample, i.e. 1 cycle after that sample is presented.
  - The minimum block period is N+1 cycles when `out_ready` is held at 1. `in_ready` is 0 for exactly the HOLD cycle.
- Backpressure: while `out_ready` = 0, the block stays in HOLD indefinitely. The upstream must hold its sample, and none is lost.
- Handshake and input-capture boundary cases:
  - The HOLD→ACCUM edge accepts no sample. The first sample of the next block can be accepted on the cycle after the handshake.
  - `in_valid` is never inspected in HOLD.
- Rounding is half-up: a fractional remainder of exactly 0.5 LSB rounds up.
- Reset mid-block: a partial block is discarded, and the next block starts counting from sample 1. Reset in HOLD drops the pending result.

## Test plan
All scenarios use LOG2N = 2 (N = 4).
- Reset: `rst` = 1 for 15 ns, with `in_valid` = 1 and `in_sum` = 9'h1FF → `out_valid` = 0, `out_avg` = 8'h00, `out_sat` = 0, `in_ready` = 1, and no sample counted.
- Basic mean: 4 back-to-back samples of 9'h01E (1.875) with `out_ready` = 1 → 1 cycle after the 4th, `out_avg` = 8'h1E, `out_sat` = 0, `out_valid` high for 1 cycle.
- Mixed values and gaps:
  - Stimulus: samples 9'h030, 9'h030, 9'h100, 9'h010, with `in_valid` = 0 for 2 cycles between each.
  - Expected: sum = 368 → `out_avg` = 8'h5C (5.75).
- Rounding:
  - 9'h001, 0, 0, 9'h001 → `out_avg` = 8'h01 (2/4 rounds up).
  - 9'h001, 0, 0, 0 → `out_avg` = 8'h00.
- Saturation: 4 samples of 9'h1FF → mean 511, so `out_avg` = 8'hFF and `out_sat` = 1. A following block of 4 × 9'h0F0 → `out_avg` = 8'hF0 and `out_sat` = 0.
- Backpressure and mid-block reset:
  - Complete a block, then hold `out_ready` = 0 for 5 cycles while `in_valid` = 1 → `in_ready` = 0 and the result is stable throughout. Release `out_ready` → the next block's first sample is accepted on the cycle after the handshake.
  - Separately, accept 2 samples of 9'h100, pulse `rst`, then send 4 samples of 9'h010 → `out_avg` = 8'h10.
